vga_framebuffer: RTL
====================

Name: vga_framebuffer

Overview:
- Pixel store directly upstream of the VGA timing controller; supplies 24-bit RGB words for the 13-bit pixel address that the controller emits.
- CPU/bus side writes and reads pixels through valid/ready handshakes with per-byte enables.
- A built-in clear engine fills the whole buffer with a single colour, one word per cycle.
- Display read port is always live, with fixed 1-cycle registered latency.

Parameters:
- ADDR_W, 13, pixel address width (matches the controller's address bus).
- DATA_W, 24, pixel width; fixed as 3 byte lanes {R[23:16], G[15:8], B[7:0]}.
- DEPTH, 2**ADDR_W, number of pixel words.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- wr_valid  in  1  CPU write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_addr  in  ADDR_W  write pixel address.
- wr_data  in  DATA_W  write pixel data.
- wr_be  in  3  byte enables; bit0=B, bit1=G, bit2=R.
- rd_valid  in  1  CPU read request.
- rd_ready  out  1  read accepted when rd_valid && rd_ready.
- rd_addr  in  ADDR_W  read pixel address.
- rd_data  out  DATA_W  CPU read data.
- rd_data_valid  out  1  one-cycle pulse, rd_data valid.
- clr_start  in  1  start clear (level sampled in IDLE).
- clr_color  in  DATA_W  fill colour, captured on start.
- clr_busy  out  1  clear in progress.
- clr_done  out  1  one-cycle pulse at clear completion.
- disp_addr  in  ADDR_W  display read address from the VGA controller.
- disp_data  out  DATA_W  display pixel, registered.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; disp_data=0, rd_data=0, rd_data_valid=0, clr_busy=0, clr_done=0, clear counter=0. Memory contents are not reset.
- Display port: disp_data <= mem[disp_addr] every cycle, in all states. Latency is exactly 1 cycle.
- Display read-during-write to the same address: returns old data. New data is visible the cycle after.
- States: IDLE, CLEAR.
- IDLE, write path: wr_ready=1 combinationally. On accept, each lane with wr_be[i]=1 is written; lanes with wr_be[i]=0 are unchanged. wr_be=0 is accepted as a no-op.
- IDLE, read path: rd_ready = !wr_valid, so a write wins over a same-cycle read. On accept, rd_data <= mem[rd_addr] and rd_data_valid=1 on the next cycle only.
- IDLE, same-cycle write and read (both valid): the write is accepted and the read stalls until the next cycle.
- IDLE -> CLEAR: when clr_start=1. Same edge: capture clr_color and set counter=0.
  - A write or read accepted in that same cycle completes normally; a written pixel is later overwritten by the clear.
- CLEAR:
  - wr_ready=0, rd_ready=0, clr_busy=1.
  - Each cycle, all 3 lanes of mem[counter] are written with the captured colour; counter increments by 1.
  - At counter==DEPTH-1 the final write happens, the state returns to IDLE, and clr_done=1 for the following cycle.
  - A clear takes exactly DEPTH cycles of busy.
  - clr_start during CLEAR is ignored; it does not restart the clear.
  - Counter is ADDR_W+1 bits wide, so there is no wrap ambiguity.
- After clr_done: if clr_start is still high in IDLE, a new clear starts. Callers pulse clr_start.
- Reset mid-clear: aborts immediately to IDLE. Memory is left partially filled (addresses < counter hold the new colour). No clr_done pulse.
- Addresses are used unsigned. There is no bounds check; every ADDR_W value maps to a word.

Decomposition:
- Shared package vga_pkg holds:
  - PIX_ADDR_W=13, PIX_W=24;
  - lane index constants LANE_B=0, LANE_G=1, LANE_R=2;
  - the state enum {ST_IDLE, ST_CLEAR};
  - VGA timing constants (640/656/752/800, 480/490/492/525) shared with the controller.
- Sub-module fb_bram_lane: simple dual-port 8-bit x DEPTH RAM.
  - One write port with we, plus two registered read ports (display and CPU).
  - Read-first behaviour.
  - Instantiated 3x, one per byte lane.

Test Plan:
- Reset then idle: disp_data=0, rd_data_valid=0, clr_busy=0, wr_ready=1, rd_ready=1.
- Write addr 0x0005 data 0x123456 be=3'b111, then display read 0x0005 -> disp_data=0x123456 one cycle after disp_addr is applied; CPU read returns 0x123456 with a single rd_data_valid pulse.
- Partial write addr 0x0005 data 0xAABBCC be=3'b010 -> read returns 0x12BB56.
- Same-cycle wr_valid (addr 0x10, data 0x000001) and rd_valid (addr 0x10) -> write accepted, rd_ready=0; the read is accepted the next cycle and returns 0x000001.
- clr_start with clr_color=0x00FF00:
  - clr_busy high for 8192 cycles and clr_done pulses once;
  - wr_ready and rd_ready are low throughout;
  - reads of addresses 0, 0x0005 and 0x1FFF all return 0x00FF00;
  - a second clr_start mid-clear is ignored (busy count is still 8192).
- Assert rst_n=0 at clear cycle 100 -> outputs reset, no clr_done. Address 50 holds the new colour; address 200 holds the previous value.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants for the VGA pixel path: pixel geometry, byte lanes,
// framebuffer states and the 640x480 timing shared with the controller.
package vga_pkg;

    localparam int PIX_ADDR_W = 13;
    localparam int PIX_W      = 24;

    localparam int LANE_B = 0;
    localparam int LANE_G = 1;
    localparam int LANE_R = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_state_e;

    localparam int H_VISIBLE    = 640;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 752;
    localparam int H_TOTAL      = 800;
    localparam int V_VISIBLE    = 480;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 492;
    localparam int V_TOTAL      = 525;

endpackage

// File: rtl/fb_bram_lane.sv
// One 8-bit byte lane of the framebuffer: single write port plus two
// registered read-first read ports (display and CPU).
module fb_bram_lane #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [7:0]        disp_q,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_q
);

    logic [7:0] mem_r [DEPTH];

    // Storage write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read registers sample pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= 8'h00;
            rd_q   <= 8'h00;
        end else begin
            disp_q <= mem_r[disp_addr];
            if (rd_en) begin
                rd_q <= mem_r[rd_addr];
            end
        end
    end

endmodule

// File: rtl/vga_framebuffer.sv
// 24-bit framebuffer: CPU write/read handshakes with byte enables, a
// one-word-per-cycle clear engine and an always-live display read port.
module vga_framebuffer
    import vga_pkg::*;
#(
    parameter int ADDR_W = PIX_ADDR_W,
    parameter int DATA_W = PIX_W,
    parameter int DEPTH  = 2**ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [2:0]        wr_be,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_color,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data
);

    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

    fb_state_e         state_r;
    logic [ADDR_W:0]   cnt_r;
    logic [DATA_W-1:0] clr_color_r;
    logic              clr_busy_r;
    logic              clr_done_r;
    logic              rd_data_valid_r;

    logic              idle_s;
    logic              rd_acc_s;
    logic [2:0]        lane_we_s;
    logic [ADDR_W-1:0] mem_waddr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [DATA_W-1:0] disp_q_s;
    logic [DATA_W-1:0] rd_q_s;

    // Handshake readiness and write-port steering between CPU and clear engine.
    always_comb begin
        idle_s   = (state_r == ST_IDLE);
        wr_ready = idle_s;
        rd_ready = idle_s && !wr_valid;
        rd_acc_s = rd_valid && rd_ready;
        if (state_r == ST_CLEAR) begin
            lane_we_s   = 3'b111;
            mem_waddr_s = cnt_r[ADDR_W-1:0];
            mem_wdata_s = clr_color_r;
        end else begin
            lane_we_s   = wr_be & {3{wr_valid}};
            mem_waddr_s = wr_addr;
            mem_wdata_s = wr_data;
        end
    end

    // Clear engine sequencing; clr_start is only looked at while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            clr_color_r <= '0;
            clr_busy_r  <= 1'b0;
            clr_done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    clr_done_r <= 1'b0;
                    if (clr_start) begin
                        state_r     <= ST_CLEAR;
                        cnt_r       <= '0;
                        clr_color_r <= clr_color;
                        clr_busy_r  <= 1'b1;
                    end else begin
                        clr_busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == LAST_CNT) begin
                        state_r    <= ST_IDLE;
                        clr_busy_r <= 1'b0;
                        clr_done_r <= 1'b1;
                    end else begin
                        clr_done_r <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    clr_busy_r <= 1'b0;
                    clr_done_r <= 1'b0;
                end
            endcase
        end
    end

    // CPU read data is valid exactly one cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_valid_r <= 1'b0;
        end else begin
            rd_data_valid_r <= rd_acc_s;
        end
    end

    // Lane i holds bits [8i+7:8i], so lane indices line up with LANE_B/G/R.
    for (genvar i = 0; i < 3; i++) begin : g_lane
        fb_bram_lane #(
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .we        (lane_we_s[i]),
            .waddr     (mem_waddr_s),
            .wdata     (mem_wdata_s[8*i +: 8]),
            .disp_addr (disp_addr),
            .disp_q    (disp_q_s[8*i +: 8]),
            .rd_en     (rd_acc_s),
            .rd_addr   (rd_addr),
            .rd_q      (rd_q_s[8*i +: 8])
        );
    end

    assign disp_data     = disp_q_s;
    assign rd_data       = rd_q_s;
    assign rd_data_valid = rd_data_valid_r;
    assign clr_busy      = clr_busy_r;
    assign clr_done      = clr_done_r;

endmodule
